regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- Sequences all writes into the 32x32 register file and shares its single write port between NREQ writeback sources (ALU, LSU, MUL/DIV).
- Arbitrates among the sources round-robin using a valid/ready handshake, and registers the granted write onto the register-file port.
- Keeps a per-register busy scoreboard. Stalls issue on RAW/WAW hazards against writes still in flight.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register index width (32 registers)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
issue_valid  input  1  decode presents an instruction this cycle
issue_rs1  input  AW  source register 1
issue_rs2  input  AW  source register 2
issue_use_rs1  input  1  instruction reads rs1
issue_use_rs2  input  1  instruction reads rs2
issue_wr  input  1  instruction will write issue_rd
issue_rd  input  AW  destination register
issue_stall  output  1  combinational; instruction must be held
wb_valid  input  NREQ  per-source write request
wb_rd  input  NREQ*AW  per-source destination, source i at bits [i*AW +: AW]
wb_data  input  NREQ*XLEN  per-source data, source i at bits [i*XLEN +: XLEN]
wb_ready  output  NREQ  combinational one-hot grant
rf_rd  output  AW  register-file write index (registered)
rf_din  output  XLEN  register-file write data (registered)
rf_rw  output  1  register-file write strobe (registered)
rf_enable  output  1  register-file enable
busy_mask  output  32  scoreboard state; bit n set = write to xn in flight
sb_err  output  1  sticky; set on a writeback to a non-busy, nonzero register

Behaviour:
- Clock/reset: clk is the clock; reset is asynchronous and active-high.
- Reset values:
  - rf_rd=0, rf_din=0, rf_rw=0, busy_mask=0, sb_err=0.
  - Round-robin pointer ptr=0.
  - rf_enable=1 during reset, so the register file runs its own clear.
  - Reset asserted mid-operation drops any registered pending write (rf_rw=0) and clears all busy bits.
- rf_enable is held 1 at all times.
- Arbitration (combinational):
  - Search starts at index ptr and wraps modulo NREQ.
  - The first i with wb_valid[i]=1 gets wb_ready[i]=1. All other ready bits are 0.
  - At most one grant per cycle. No grants while reset is high.
- Accept: a handshake is wb_valid[i] & wb_ready[i]. On the posedge after an accept:
  - ptr <= (i+1) mod NREQ. With no accept, ptr holds.
  - rf_rd <= wb_rd[i], rf_din <= wb_data[i].
  - rf_rw <= (wb_rd[i]!=0). Writes to x0 are consumed but suppressed.
  - With no accept, rf_rw <= 0 and rf_rd/rf_din hold.
- Latency: 1 cycle from accept to rf_rw high. The register file commits on the following negedge. At most one write per cycle.
- Sources hold wb_valid/wb_rd/wb_data stable until accepted. They may drop valid only after acceptance.
- Scoreboard set: at the posedge where issue_valid & ~issue_stall & issue_wr & issue_rd!=0, busy[issue_rd] <= 1.
- Scoreboard clear: at the posedge of an accept with wb_rd!=0, busy[wb_rd] <= 0.
  - A read issued in the cycle after the clear sees the new value: rf_rw is high that cycle, the negedge write precedes the next posedge read.
- Stall (combinational): issue_stall = issue_valid & (RAW | WAW), where:
  - RAW = (issue_use_rs1 & busy[issue_rs1]) | (issue_use_rs2 & busy[issue_rs2]).
  - WAW = issue_wr & busy[issue_rd].
  - busy[0] is always 0.
  - Stall is evaluated against the pre-edge busy_mask. A register being cleared this cycle still stalls for one cycle.
- Simultaneous set and clear of the same register cannot occur: issue stalls while busy. If both happen on different registers in one edge, both take effect.
- sb_err: set when an accept targets a nonzero register whose busy bit is 0. Cleared only by reset. The write still proceeds.

Test Plan:
- Reset → all registered outputs 0, rf_enable=1. Release reset with wb_valid=3'b000 → rf_rw stays 0, wb_ready=3'b000.
- Fairness: wb_valid=3'b111 held with rd=1,2,3 and data=A,B,C; busy set for x1–x3 → grants 001,010,100 on consecutive cycles. rf_rd=1,2,3 with rf_din=A,B,C, each one cycle after its grant. busy_mask returns to 0.
- RAW: issue rd=5 (issue_wr=1), then issue rs1=5 → stall=1 until the source-1 accept of rd=5. stall still 1 in the accept cycle, 0 in the next cycle. The read returns the new data.
- WAW plus x0: issue rd=7 twice back-to-back → second stalls. Writeback to rd=0 → wb_ready=1, rf_rw=0, sb_err stays 0.
- Spurious writeback: rd=9 with busy[9]=0 → rf_rw=1, rf_rd=9, sb_err=1 and stays set.
- Reset mid-flight: busy_mask=0x0000_0006, an accept occurs, reset asserts before the next edge → rf_rw=0, busy_mask=0, ptr=0 (next grant goes to source 0).

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// Writeback sequencer for the 32-entry register file: round-robin arbitration
// of NREQ writeback sources onto the single write port, plus a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scoreboard #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rs1,
  input  logic [AW-1:0]        issue_rs2,
  input  logic                 issue_use_rs1,
  input  logic                 issue_use_rs2,
  input  logic                 issue_wr,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_stall,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*AW-1:0]   wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_din,
  output logic                 rf_rw,
  output logic                 rf_enable,
  output logic [(2**AW)-1:0]   busy_mask,
  output logic                 sb_err
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [NREG-1:0] r_busy;
  logic [AW-1:0]   r_rf_rd;
  logic [XLEN-1:0] r_rf_din;
  logic            r_rf_rw;
  logic            r_sb_err;

  logic [AW-1:0]   w_rd_arr   [NREQ];
  logic [XLEN-1:0] w_data_arr [NREQ];
  logic            w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_ready;
  logic [AW-1:0]   w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  logic            w_raw;
  logic            w_waw;
  logic            w_stall;
  logic            w_set;
  logic            w_clr;
  logic [NREG-1:0] w_busy_next;
  logic [PW-1:0]   w_ptr_next;

  // Unpack the flat per-source buses
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_rd_arr[g]   = wb_rd[g*AW +: AW];
    assign w_data_arr[g] = wb_data[g*XLEN +: XLEN];
  end

  // Round-robin search starting at r_ptr; no grants while in reset
  always_comb begin
    int unsigned v_idx;
    v_idx     = 0;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_ready   = '0;
    if (!reset) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        v_idx = (32'(r_ptr) + k) % NREQ;
        if (!w_gnt && wb_valid[PW'(v_idx)]) begin
          w_gnt     = 1'b1;
          w_gnt_idx = PW'(v_idx);
        end
      end
    end
    if (w_gnt) w_ready[w_gnt_idx] = 1'b1;
  end

  assign wb_ready   = w_ready;
  assign w_acc_rd   = w_rd_arr[w_gnt_idx];
  assign w_acc_data = w_data_arr[w_gnt_idx];

  // Hazard detection against the pre-edge scoreboard; x0 is never busy
  always_comb begin
    w_raw = (issue_use_rs1 & r_busy[issue_rs1]) | (issue_use_rs2 & r_busy[issue_rs2]);
    w_waw = issue_wr & r_busy[issue_rd];
    w_stall = issue_valid & (w_raw | w_waw);
    w_set = issue_valid & ~w_stall & issue_wr & (issue_rd != '0);
    w_clr = w_gnt & (w_acc_rd != '0);
  end

  assign issue_stall = w_stall;

  // Next scoreboard state and pointer; set and clear never hit the same register
  always_comb begin
    w_busy_next = r_busy;
    if (w_clr) w_busy_next[w_acc_rd] = 1'b0;
    if (w_set) w_busy_next[issue_rd] = 1'b1;
    w_ptr_next = r_ptr;
    if (w_gnt) begin
      w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
    end
  end

  // Registered write port, scoreboard, pointer and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_busy   <= '0;
      r_rf_rd  <= '0;
      r_rf_din <= '0;
      r_rf_rw  <= 1'b0;
      r_sb_err <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_busy  <= w_busy_next;
      r_rf_rw <= w_clr;
      if (w_gnt) begin
        r_rf_rd  <= w_acc_rd;
        r_rf_din <= w_acc_data;
      end
      if (w_clr && !r_busy[w_acc_rd]) r_sb_err <= 1'b1;
    end
  end

  assign rf_rd     = r_rf_rd;
  assign rf_din    = r_rf_din;
  assign rf_rw     = r_rf_rw;
  assign rf_enable = 1'b1;
  assign busy_mask = r_busy;
  assign sb_err    = r_sb_err;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: arbitration order, scoreboard
// hazards, x0 suppression, sticky error and asynchronous reset.
module tb_regfile_wb_scoreboard;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rs1;
  logic [AW-1:0]        issue_rs2;
  logic                 issue_use_rs1;
  logic                 issue_use_rs2;
  logic                 issue_wr;
  logic [AW-1:0]        issue_rd;
  logic                 issue_stall;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*AW-1:0]   wb_rd;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;
  logic [AW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_din;
  logic                 rf_rw;
  logic                 rf_enable;
  logic [31:0]          busy_mask;
  logic                 sb_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_scoreboard #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_stall  (issue_stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .rf_rd        (rf_rd),
    .rf_din       (rf_din),
    .rf_rw        (rf_rw),
    .rf_enable    (rf_enable),
    .busy_mask    (busy_mask),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    wb_rd[i*AW +: AW]       = rd;
    wb_data[i*XLEN +: XLEN] = data;
  endtask

  task automatic issue(input logic v, input logic wr, input logic [AW-1:0] rd,
                       input logic u1, input logic [AW-1:0] rs1);
    issue_valid   = v;
    issue_wr      = wr;
    issue_rd      = rd;
    issue_use_rs1 = u1;
    issue_rs1     = rs1;
  endtask

  initial begin
    reset         = 1'b1;
    issue_rs2     = '0;
    issue_use_rs2 = 1'b0;
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    wb_valid = 3'b111;
    wb_rd    = '0;
    wb_data  = '0;
    step();
    step();
    // Reset state; no grants while reset is high
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_din", 64'(rf_din), 64'd0);
    chk("rst_rf_rw", 64'(rf_rw), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);
    chk("rst_rf_enable", 64'(rf_enable), 64'd1);
    chk("rst_no_grant", 64'(wb_ready), 64'd0);

    reset    = 1'b0;
    wb_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(wb_ready), 64'd0);
    step();
    chk("idle_rf_rw", 64'(rf_rw), 64'd0);

    // Mark x1..x3 busy
    issue(1'b1, 1'b1, 5'd1, 1'b0, 5'd0);
    step();
    issue(1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
    step();
    issue(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("busy_123", 64'(busy_mask), 64'h0000_000e);

    // Fairness with all three sources held valid
    set_src(0, 5'd1, 32'h0000_00aa);
    set_src(1, 5'd2, 32'h0000_00bb);
    set_src(2, 5'd3, 32'h0000_00cc);
    wb_valid = 3'b111;
    #1;
    chk("rr_gnt0", 64'(wb_ready), 64'b001);
    step();
    chk("rr_rf_rw0", 64'(rf_rw), 64'd1);
    chk("rr_rf_rd0", 64'(rf_rd), 64'd1);
    chk("rr_rf_din0", 64'(rf_din), 64'h0000_00aa);
    chk("rr_gnt1", 64'(wb_ready), 64'b010);
    step();
    chk("rr_rf_rd1", 64'(rf_rd), 64'd2);
    chk("rr_rf_din1", 64'(rf_din), 64'h0000_00bb);
    chk("rr_gnt2", 64'(wb_ready), 64'b100);
    step();
    wb_valid = 3'b000;
    chk("rr_rf_rd2", 64'(rf_rd), 64'd3);
    chk("rr_rf_din2", 64'(rf_din), 64'h0000_00cc);
    chk("rr_busy_clear", 64'(busy_mask), 64'd0);
    step();
    chk("rr_rf_rw_drop", 64'(rf_rw), 64'd0);
    chk("rr_no_err", 64'(sb_err), 64'd0);

    // RAW on x5; pointer is back at source 0
    issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    chk("raw_issue_ok", 64'(issue_stall), 64'd0);
    step();
    chk("raw_busy5", 64'(busy_mask), 64'h0000_0020);
    issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd5);
    #1;
    chk("raw_stall", 64'(issue_stall), 64'd1);
    step();
    chk("raw_stall_hold", 64'(issue_stall), 64'd1);
    set_src(1, 5'd5, 32'h5555_0005);
    wb_valid = 3'b010;
    #1;
    chk("raw_gnt1", 64'(wb_ready), 64'b010);
    chk("raw_stall_accept", 64'(issue_stall), 64'd1);
    step();
    wb_valid = 3'b000;
    chk("raw_stall_release", 64'(issue_stall), 64'd0);
    chk("raw_rf_rw", 64'(rf_rw), 64'd1);
    chk("raw_rf_rd", 64'(rf_rd), 64'd5);
    chk("raw_rf_din", 64'(rf_din), 64'h5555_0005);
    chk("raw_busy", 64'(busy_mask), 64'd0);
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // WAW on x7; pointer is now at source 2
    issue(1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    chk("waw_first_ok", 64'(issue_stall), 64'd0);
    step();
    chk("waw_busy7", 64'(busy_mask), 64'h0000_0080);
    chk("waw_second_stall", 64'(issue_stall), 64'd1);
    step();
    chk("waw_busy_hold", 64'(busy_mask), 64'h0000_0080);
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Writeback to x0 is consumed but suppressed
    set_src(2, 5'd0, 32'hdead_beef);
    wb_valid = 3'b100;
    #1;
    chk("x0_gnt", 64'(wb_ready), 64'b100);
    step();
    wb_valid = 3'b000;
    chk("x0_rf_rw", 64'(rf_rw), 64'd0);
    chk("x0_sb_err", 64'(sb_err), 64'd0);
    chk("x0_busy", 64'(busy_mask), 64'h0000_0080);

    // Retire x7 via source 0 (pointer wrapped to 0)
    set_src(0, 5'd7, 32'h0000_0777);
    wb_valid = 3'b001;
    #1;
    chk("x7_gnt", 64'(wb_ready), 64'b001);
    step();
    wb_valid = 3'b000;
    chk("x7_busy", 64'(busy_mask), 64'd0);

    // Spurious writeback to non-busy x9 still writes and sets sticky error
    set_src(1, 5'd9, 32'h0909_0909);
    wb_valid = 3'b010;
    step();
    wb_valid = 3'b000;
    chk("sp_rf_rw", 64'(rf_rw), 64'd1);
    chk("sp_rf_rd", 64'(rf_rd), 64'd9);
    chk("sp_sb_err", 64'(sb_err), 64'd1);
    step();
    chk("sp_sb_err_sticky", 64'(sb_err), 64'd1);
    chk("sp_rf_rw_drop", 64'(rf_rw), 64'd0);

    // Reset mid-flight: x1,x2 busy, accept from source 1 (pointer -> 2), then reset
    issue(1'b1, 1'b1, 5'd1, 1'b0, 5'd0);
    step();
    issue(1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("mid_busy", 64'(busy_mask), 64'h0000_0006);
    set_src(1, 5'd1, 32'h1111_1111);
    wb_valid = 3'b010;
    #1;
    chk("mid_gnt", 64'(wb_ready), 64'b010);
    step();
    wb_valid = 3'b000;
    chk("mid_rf_rw_pre", 64'(rf_rw), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rf_rw", 64'(rf_rw), 64'd0);
    chk("mid_busy_clr", 64'(busy_mask), 64'd0);
    chk("mid_sb_err_clr", 64'(sb_err), 64'd0);
    chk("mid_rf_enable", 64'(rf_enable), 64'd1);
    step();
    reset    = 1'b0;
    wb_valid = 3'b111;
    #1;
    chk("mid_ptr0", 64'(wb_ready), 64'b001);
    wb_valid = 3'b000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
